// File: rtl/spi_reg_target.sv
// SPI mode-0 target exposing an 8-bit register file to an external host.
// Host pins are oversampled in the clk domain; frames are RW|ADDR[6:0]|DATA[7:0], MSB first.
module spi_reg_target #(
  parameter int NREGS       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               sclk,
  input  logic               cs_n,
  input  logic               mosi,
  output logic               miso,
  output logic               miso_oe,
  output logic [8*NREGS-1:0] regs_flat,
  output logic               wr_valid,
  output logic [6:0]         wr_addr,
  output logic [7:0]         wr_data
);

  typedef enum logic [2:0] {SKIP, IDLE, CMD, DATA, DONE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_s, mosi_s, rise, fall;

  // cs_n synchroniser resets to "selected" so SKIP waits for a real cs_n high
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev_q;
  assign fall   = ~sclk_s & sclk_prev_q;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [6:0] shift_q;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] tx_q;
  logic       miso_q;
  logic       oe_q;
  logic [7:0] regs_q [NREGS];
  logic       wr_valid_q;
  logic [6:0] wr_addr_q;
  logic [7:0] wr_data_q;

  logic [7:0] shift_byte_d;
  logic [7:0] rd_byte_d;
  logic       addr_hit_d;

  assign shift_byte_d = {shift_q, mosi_s};

  // Out-of-range addresses read as 0x00 and never match a write target
  always_comb begin
    rd_byte_d  = 8'h00;
    addr_hit_d = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (addr_q == 7'(i)) begin
        rd_byte_d  = regs_q[i];
        addr_hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SKIP;
      cnt_q      <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else begin
      wr_valid_q <= 1'b0;
      if (!ena) begin
        state_q <= SKIP;
        miso_q  <= 1'b0;
        oe_q    <= 1'b0;
      end else if (state_q != SKIP && cs_s) begin
        state_q <= IDLE;
        miso_q  <= 1'b0;
        oe_q    <= 1'b0;
      end else begin
        unique case (state_q)
          SKIP: begin
            if (cs_s) state_q <= IDLE;
          end
          IDLE: begin
            state_q <= CMD;
            cnt_q   <= '0;
            oe_q    <= 1'b1;
            miso_q  <= 1'b0;
          end
          CMD: begin
            if (rise) begin
              shift_q <= shift_byte_d[6:0];
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd7) begin
                rw_q    <= shift_byte_d[7];
                addr_q  <= shift_byte_d[6:0];
                state_q <= DATA;
              end
            end
          end
          DATA: begin
            if (rise) begin
              shift_q <= shift_byte_d[6:0];
              cnt_q   <= cnt_q + 4'd1;
              if (cnt_q == 4'd15) begin
                state_q <= DONE;
                miso_q  <= 1'b0;
                if (rw_q && addr_hit_d) begin
                  for (int i = 0; i < NREGS; i++) begin
                    if (addr_q == 7'(i)) regs_q[i] <= shift_byte_d;
                  end
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= addr_q;
                  wr_data_q  <= shift_byte_d;
                end
              end
            end else if (fall && !rw_q) begin
              // First fall after the command byte snapshots the register
              if (cnt_q == 4'd8) begin
                miso_q <= rd_byte_d[7];
                tx_q   <= {rd_byte_d[6:0], 1'b0};
              end else begin
                miso_q <= tx_q[7];
                tx_q   <= {tx_q[6:0], 1'b0};
              end
            end
          end
          DONE: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= SKIP;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

  assign miso     = miso_q;
  assign miso_oe  = oe_q & ena;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_reg_target.sv
// Self-checking bench for spi_reg_target: directed frame table, reset/enable corner
// sequences and a scoreboarded run of random back-to-back frames.
`timescale 1ns/1ps
module tb_spi_reg_target;

  localparam int NREGS = 8;
  localparam int PH    = 4;

  logic             clk;
  logic             rst;
  logic             ena;
  logic             sclk;
  logic             csN;
  logic             mosi;
  logic             miso;
  logic             misoOe;
  logic [8*NREGS-1:0] regsFlat;
  logic             wrValid;
  logic [6:0]       wrAddr;
  logic [7:0]       wrData;

  spi_reg_target #(.NREGS(NREGS), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .sclk      (sclk),
    .cs_n      (csN),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (misoOe),
    .regs_flat (regsFlat),
    .wr_valid  (wrValid),
    .wr_addr   (wrAddr),
    .wr_data   (wrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wvTotal = 0;

  logic [7:0] rxByte;
  bit         extraBad;
  bit         oeHigh;
  logic       oeAfter;

  // Count every cycle wr_valid is high; a correct write contributes exactly one
  always @(negedge clk) begin
    if (wrValid === 1'b1) wvTotal++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Clocks bits first..first+count-1 of a frame; bits past 16 send mosi=1
  task automatic shiftBits(input logic [15:0] f, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      mosi = (i < 16) ? f[15-i] : 1'b1;
      repeat (PH) @(negedge clk);
      sclk = 1'b1;
      if (i >= 8 && i < 16) rxByte = {rxByte[6:0], miso};
      if (i >= 16 && miso !== 1'b0) extraBad = 1'b1;
      if (misoOe === 1'b1) oeHigh = 1'b1;
      repeat (PH) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] f, input int nbits);
    rxByte   = 8'h00;
    extraBad = 1'b0;
    oeHigh   = 1'b0;
    csN = 1'b0;
    repeat (PH) @(negedge clk);
    shiftBits(f, 0, nbits);
    repeat (PH) @(negedge clk);
    csN = 1'b1;
    repeat (PH + 2) @(negedge clk);
    oeAfter = misoOe;
    repeat (PH) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    logic        enaV;
    int          expWr;
    logic        chkRx;
    logic [7:0]  expRx;
    logic [63:0] expFlat;
  } vec_t;

  vec_t vecs [16];
  logic [7:0]  model [NREGS];
  logic [63:0] expFlat;
  int          wrBefore;

  initial begin
    vecs[0]  = '{16'h83A5, 16, 1'b1, 1, 1'b0, 8'h00, 64'h00000000_A5000000};
    vecs[1]  = '{16'h0300, 16, 1'b1, 0, 1'b1, 8'hA5, 64'h00000000_A5000000};
    vecs[2]  = '{16'h8A5A, 16, 1'b1, 0, 1'b0, 8'h00, 64'h00000000_A5000000};
    vecs[3]  = '{16'h0A00, 16, 1'b1, 0, 1'b1, 8'h00, 64'h00000000_A5000000};
    vecs[4]  = '{16'h8155, 12, 1'b1, 0, 1'b0, 8'h00, 64'h00000000_A5000000};
    vecs[5]  = '{16'h8155, 16, 1'b1, 1, 1'b0, 8'h00, 64'h00000000_A5005500};
    vecs[6]  = '{16'h8477, 16, 1'b0, 0, 1'b0, 8'h00, 64'h00000000_A5005500};
    vecs[7]  = '{16'h8477, 16, 1'b1, 1, 1'b0, 8'h00, 64'h00000077_A5005500};
    vecs[8]  = '{16'h0100, 16, 1'b1, 0, 1'b1, 8'h55, 64'h00000077_A5005500};
    vecs[9]  = '{16'h0400, 16, 1'b1, 0, 1'b1, 8'h77, 64'h00000077_A5005500};
    vecs[10] = '{16'h0700, 16, 1'b1, 0, 1'b1, 8'h00, 64'h00000077_A5005500};
    vecs[11] = '{16'h87C3, 16, 1'b1, 1, 1'b0, 8'h00, 64'hC3000077_A5005500};
    vecs[12] = '{16'h0700, 16, 1'b1, 0, 1'b1, 8'hC3, 64'hC3000077_A5005500};
    vecs[13] = '{16'hFF12, 16, 1'b1, 0, 1'b0, 8'h00, 64'hC3000077_A5005500};
    vecs[14] = '{16'h8611, 20, 1'b1, 1, 1'b0, 8'h00, 64'hC3110077_A5005500};
    vecs[15] = '{16'h0600, 20, 1'b1, 0, 1'b1, 8'h11, 64'hC3110077_A5005500};

    rst = 1'b1; ena = 1'b1; sclk = 1'b0; csN = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset regs", regsFlat, 64'h0);
    checkOutput("reset miso", miso, 1'b0);
    checkOutput("reset miso_oe", misoOe, 1'b0);
    checkOutput("reset wr_valid", wrValid, 1'b0);
    checkOutput("reset wr_addr", wrAddr, 7'h00);
    checkOutput("reset wr_data", wrData, 8'h00);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      if (!vecs[v].enaV) begin
        ena = 1'b0;
        repeat (PH) @(negedge clk);
      end
      wrBefore = wvTotal;
      applyStimulus(vecs[v].frame, vecs[v].nbits);
      if (!vecs[v].enaV) begin
        ena = 1'b1;
        repeat (PH) @(negedge clk);
      end
      checkOutput($sformatf("v%0d wr_valid cycles", v), 64'(wvTotal - wrBefore), 64'(vecs[v].expWr));
      if (vecs[v].expWr == 1) begin
        checkOutput($sformatf("v%0d wr_addr", v), wrAddr, vecs[v].frame[14:8]);
        checkOutput($sformatf("v%0d wr_data", v), wrData, vecs[v].frame[7:0]);
      end
      if (vecs[v].chkRx) checkOutput($sformatf("v%0d read data", v), rxByte, vecs[v].expRx);
      checkOutput($sformatf("v%0d miso_oe in frame", v), oeHigh, vecs[v].enaV);
      checkOutput($sformatf("v%0d miso_oe after cs_n", v), oeAfter, 1'b0);
      checkOutput($sformatf("v%0d regs", v), regsFlat, vecs[v].expFlat);
      if (vecs[v].nbits > 16) checkOutput($sformatf("v%0d miso on extra edges", v), extraBad, 1'b0);
    end

    // Reset after 6 bits with cs_n held low: rest of the frame must be ignored
    wrBefore = wvTotal;
    rxByte = 8'h00; extraBad = 1'b0; oeHigh = 1'b0;
    csN = 1'b0;
    repeat (PH) @(negedge clk);
    shiftBits(16'h82FF, 0, 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    shiftBits(16'h82FF, 6, 10);
    repeat (PH) @(negedge clk);
    checkOutput("rst mid-frame miso_oe", misoOe, 1'b0);
    csN = 1'b1;
    repeat (2 * PH) @(negedge clk);
    checkOutput("rst mid-frame wr_valid cycles", 64'(wvTotal - wrBefore), 64'd0);
    checkOutput("rst mid-frame regs", regsFlat, 64'h0);
    wrBefore = wvTotal;
    applyStimulus(16'h82FF, 16);
    checkOutput("post-rst write wr_valid cycles", 64'(wvTotal - wrBefore), 64'd1);
    checkOutput("post-rst write regs", regsFlat, 64'h00000000_00FF0000);

    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    model[2] = 8'hFF;

    for (int r = 0; r < 20; r++) begin
      logic        rw;
      logic [6:0]  addr;
      logic [7:0]  data;
      logic [7:0]  expRx;
      int          expWr;
      rw   = 1'($urandom_range(0, 1));
      addr = 7'($urandom_range(0, 9));
      data = 8'($urandom_range(0, 255));
      expWr = 0;
      expRx = 8'h00;
      if (rw) begin
        if (addr < 7'(NREGS)) begin
          model[addr[2:0]] = data;
          expWr = 1;
        end
      end else if (addr < 7'(NREGS)) begin
        expRx = model[addr[2:0]];
      end
      wrBefore = wvTotal;
      applyStimulus({rw, addr, rw ? data : 8'h00}, 16);
      for (int i = 0; i < NREGS; i++) expFlat[8*i +: 8] = model[i];
      checkOutput($sformatf("rnd%0d wr_valid cycles", r), 64'(wvTotal - wrBefore), 64'(expWr));
      if (!rw) checkOutput($sformatf("rnd%0d read a%0d", r, addr), rxByte, expRx);
      checkOutput($sformatf("rnd%0d regs", r), regsFlat, expFlat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
